// File: rtl/bin2bcd_seq_if.sv
// bin2bcd_seq_if: start/ready/valid handshake and result bus of the
// sequential binary-to-BCD converter.
//   start, binary          : request and operand (master -> slave)
//   ready                  : converter idle, start will be accepted
//   valid                  : one-cycle result strobe
//   bcd, blank, overflow   : held result, leading-zero mask, saturation flag
interface bin2bcd_seq_if #(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
);
    logic                  start;
    logic [BIN_W-1:0]      binary;
    logic                  ready;
    logic                  valid;
    logic [4*DIGITS-1:0]   bcd;
    logic [DIGITS-1:0]     blank;
    logic                  overflow;

    modport master (
        output start, binary,
        input  ready, valid, bcd, blank, overflow
    );

    modport slave (
        input  start, binary,
        output ready, valid, bcd, blank, overflow
    );
endinterface

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble binary-to-BCD converter, one input
// bit per clock. Results saturate to all nines when the value does not fit
// in DIGITS, and a leading-zero mask is produced for display blanking.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of bin2bcd_seq_if (start/binary in; ready, valid,
//           bcd, blank, overflow out; all outputs come straight from flops)
module bin2bcd_seq #(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    bin2bcd_seq_if.slave  bus
);
    localparam int BCD_W  = 4 * DIGITS;
    localparam int WORK_W = BCD_W + BIN_W;
    localparam int CNT_W  = $clog2(BIN_W) + 1;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_CONV = 1'b1
    } state_t;

    // Add 3 to every BCD digit that is 5 or more, so the following shift
    // carries correctly into the next decimal digit.
    function automatic logic [BCD_W-1:0] add3_digits(input logic [BCD_W-1:0] d);
        logic [BCD_W-1:0] r;
        r = d;
        for (int i = 0; i < DIGITS; i++) begin
            if (d[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = d[4*i +: 4] + 4'd3;
            end else begin
                r[4*i +: 4] = d[4*i +: 4];
            end
        end
        return r;
    endfunction

    // Bit d (d >= 1) set when digit d and every digit above it are zero.
    // Digit 0 is never blanked so a zero value still shows "0".
    function automatic logic [DIGITS-1:0] blank_mask(input logic [BCD_W-1:0] d);
        logic [DIGITS-1:0] m;
        logic              z;
        m = {DIGITS{1'b0}};
        z = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            z    = z & (d[4*i +: 4] == 4'd0);
            m[i] = z;
        end
        return m;
    endfunction

    localparam logic [DIGITS-1:0] BLANK_RST = blank_mask({BCD_W{1'b0}});
    localparam logic [BCD_W-1:0]  BCD_SAT   = {DIGITS{4'h9}};

    state_t              state_q, state_d;
    logic [WORK_W-1:0]   work_q, work_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                sticky_q, sticky_d;
    logic                valid_q, valid_d;
    logic [BCD_W-1:0]    bcd_q, bcd_d;
    logic [DIGITS-1:0]   blank_q, blank_d;
    logic                ovf_q, ovf_d;

    logic [WORK_W-1:0]   adj_s;
    logic [WORK_W-1:0]   shift_s;
    logic                sticky_s;
    logic [BCD_W-1:0]    final_s;

    // One double-dabble iteration on the working register, plus the
    // saturated result it would produce if this were the last iteration.
    always_comb begin
        adj_s    = {add3_digits(work_q[WORK_W-1 -: BCD_W]), work_q[BIN_W-1:0]};
        shift_s  = {adj_s[WORK_W-2:0], 1'b0};
        // Anything pushed out of the top digit means the value did not fit.
        sticky_s = sticky_q | adj_s[WORK_W-1];
        if (sticky_s) begin
            final_s = BCD_SAT;
        end else begin
            final_s = shift_s[WORK_W-1 -: BCD_W];
        end
    end

    // Next-state and datapath control for the IDLE/CONV sequencer.
    always_comb begin
        state_d  = state_q;
        work_d   = work_q;
        cnt_d    = cnt_q;
        sticky_d = sticky_q;
        valid_d  = 1'b0;
        bcd_d    = bcd_q;
        blank_d  = blank_q;
        ovf_d    = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    work_d   = {{BCD_W{1'b0}}, bus.binary};
                    cnt_d    = {CNT_W{1'b0}};
                    sticky_d = 1'b0;
                    state_d  = S_CONV;
                end else begin
                    state_d  = S_IDLE;
                end
            end
            S_CONV: begin
                work_d   = shift_s;
                cnt_d    = cnt_q + CNT_W'(1);
                sticky_d = sticky_s;
                if (cnt_q == CNT_W'(BIN_W - 1)) begin
                    bcd_d   = final_s;
                    blank_d = blank_mask(final_s);
                    ovf_d   = sticky_s;
                    valid_d = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_CONV;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            work_q   <= {WORK_W{1'b0}};
            cnt_q    <= {CNT_W{1'b0}};
            sticky_q <= 1'b0;
            valid_q  <= 1'b0;
            bcd_q    <= {BCD_W{1'b0}};
            blank_q  <= BLANK_RST;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            work_q   <= work_d;
            cnt_q    <= cnt_d;
            sticky_q <= sticky_d;
            valid_q  <= valid_d;
            bcd_q    <= bcd_d;
            blank_q  <= blank_d;
            ovf_q    <= ovf_d;
        end
    end

    assign bus.ready    = (state_q == S_IDLE);
    assign bus.valid    = valid_q;
    assign bus.bcd      = bcd_q;
    assign bus.blank    = blank_q;
    assign bus.overflow = ovf_q;

endmodule
